// File: rtl/param_queue.sv
// Parameterised synchronous FIFO with registered one-cycle read, flush and threshold flags.
// Optional sticky overflow/underflow outputs are enabled by defining PARAM_QUEUE_ERR_FLAGS_EN.
module param_queue #(
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       put,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       get,
  output logic [WIDTH-1:0]           d_out,
  output logic                       d_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
`ifdef PARAM_QUEUE_ERR_FLAGS_EN
  output logic                       overflow,
  output logic                       underflow,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] d_out_reg;
  logic             d_valid_reg;
  logic             wr_en, rd_en;

  // Flush wins over both requests; a full queue never accepts a write even when a read frees a slot.
  assign wr_en = put & ~full  & ~flush;
  assign rd_en = get & ~empty & ~flush;

  assign empty        = (count_reg == '0);
  assign full         = (count_reg == CW'(DEPTH));
  assign almost_empty = (32'(count_reg) <= AE_LEVEL);
  assign almost_full  = (32'(count_reg) >= AF_LEVEL);
  assign count        = count_reg;
  assign d_out        = d_out_reg;
  assign d_valid      = d_valid_reg;

  // Storage has no reset so it maps onto block RAM; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= d_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      d_out_reg   <= '0;
      d_valid_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      d_out_reg   <= '0;
      d_valid_reg <= 1'b0;
    end else begin
      d_valid_reg <= rd_en;
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        d_out_reg  <= mem[rd_ptr_reg];
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef PARAM_QUEUE_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (put && full)
        overflow_reg <= 1'b1;
      if (get && empty)
        underflow_reg <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_param_queue.sv
// Directed self-checking bench for param_queue (DEPTH=8, WIDTH=12); checks error flags when
// PARAM_QUEUE_ERR_FLAGS_EN is defined.
module tb_param_queue;

  localparam int WIDTH = 12;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             put;
  logic [WIDTH-1:0] d_in;
  logic             get;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [3:0]       count;
`ifdef PARAM_QUEUE_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  param_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .put          (put),
    .d_in         (d_in),
    .get          (get),
    .d_out        (d_out),
    .d_valid      (d_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
`ifdef PARAM_QUEUE_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got %0d expected %0d ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    put   = 1'b0;
    get   = 1'b0;
    d_in  = '0;
    #3;
    check("rst_empty",    32'(empty),        32'd1);
    check("rst_full",     32'(full),         32'd0);
    check("rst_ae",       32'(almost_empty), 32'd1);
    check("rst_af",       32'(almost_full),  32'd0);
    check("rst_count",    32'(count),        32'd0);
    check("rst_dvalid",   32'(d_valid),      32'd0);
    check("rst_dout",     32'(d_out),        32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Fill 1..8
    for (int i = 1; i <= 8; i++) begin
      put  = 1'b1;
      d_in = WIDTH'(i);
      step();
      check("fill_count", 32'(count),       32'(i));
      check("fill_af",    32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      check("fill_full",  32'(full),        (i == 8) ? 32'd1 : 32'd0);
    end
    // Ninth put with a simultaneous get must still be refused
    d_in = 12'd99;
    get  = 1'b1;
    step();
    put = 1'b0;
    check("ovf_count",  32'(count),   32'd7);
    check("ovf_dout",   32'(d_out),   32'd1);
    check("ovf_dvalid", 32'(d_valid), 32'd1);
`ifdef PARAM_QUEUE_ERR_FLAGS_EN
    check("ovf_flag",   32'(overflow), 32'd1);
`endif

    // Drain remaining 2..8 in order
    for (int i = 2; i <= 8; i++) begin
      get = 1'b1;
      step();
      check("drain_dvalid", 32'(d_valid),      32'd1);
      check("drain_dout",   32'(d_out),        32'(i));
      check("drain_ae",     32'(almost_empty), ((8 - i) <= 2) ? 32'd1 : 32'd0);
    end
    get = 1'b0;
    step();
    check("idle_dvalid", 32'(d_valid), 32'd0);
    check("idle_dout",   32'(d_out),   32'd8);
    check("idle_empty",  32'(empty),   32'd1);

    // Prime four words, then stream put+get across pointer wrap
    for (int i = 0; i < 4; i++) begin
      put  = 1'b1;
      d_in = WIDTH'(100 + i);
      step();
    end
    check("prime_count", 32'(count), 32'd4);
    get = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d_in = WIDTH'(104 + k);
      step();
      check("wrap_count",  32'(count),   32'd4);
      check("wrap_dvalid", 32'(d_valid), 32'd1);
      check("wrap_dout",   32'(d_out),   32'(100 + k));
    end
    get  = 1'b0;
    d_in = 12'd200;
    step();
    put = 1'b0;
    check("pre_flush_count", 32'(count), 32'd5);

    // Flush beats put and get
    flush = 1'b1;
    put   = 1'b1;
    get   = 1'b1;
    d_in  = 12'd300;
    step();
    flush = 1'b0;
    put   = 1'b0;
    get   = 1'b0;
    check("flush_count",  32'(count),   32'd0);
    check("flush_empty",  32'(empty),   32'd1);
    check("flush_dvalid", 32'(d_valid), 32'd0);
    check("flush_dout",   32'(d_out),   32'd0);
`ifdef PARAM_QUEUE_ERR_FLAGS_EN
    check("flush_ovf",    32'(overflow), 32'd0);
`endif
    put  = 1'b1;
    d_in = 12'd7;
    step();
    put = 1'b0;
    get = 1'b1;
    step();
    get = 1'b0;
    check("post_flush_dout",  32'(d_out), 32'd7);
    check("post_flush_count", 32'(count), 32'd0);

    // Asynchronous reset at count=3, checked before the next edge
    put = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in = WIDTH'(50 + i);
      step();
    end
    put = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    get = 1'b1;
    step();
    get = 1'b0;
    check("pre_rst_dout", 32'(d_out), 32'd50);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",  32'(count),        32'd0);
    check("arst_empty",  32'(empty),        32'd1);
    check("arst_ae",     32'(almost_empty), 32'd1);
    check("arst_dvalid", 32'(d_valid),      32'd0);
    check("arst_dout",   32'(d_out),        32'd0);
    step();
    rst_n = 1'b1;
    put   = 1'b1;
    d_in  = 12'd2013;
    step();
    put = 1'b0;
    get = 1'b1;
    step();
    get = 1'b0;
    check("rst_rw_dvalid", 32'(d_valid), 32'd1);
    check("rst_rw_dout",   32'(d_out),   32'd2013);
    check("rst_rw_count",  32'(count),   32'd0);

    // get with put while empty: no fall-through
    put  = 1'b1;
    get  = 1'b1;
    d_in = 12'd55;
    step();
    put = 1'b0;
    get = 1'b0;
    check("uf_dvalid", 32'(d_valid), 32'd0);
    check("uf_count",  32'(count),   32'd1);
    check("uf_dout",   32'(d_out),   32'd2013);
`ifdef PARAM_QUEUE_ERR_FLAGS_EN
    check("uf_flag",   32'(underflow), 32'd1);
`endif
    get = 1'b1;
    step();
    get = 1'b0;
    check("uf_read_dout", 32'(d_out), 32'd55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
